// File: rtl/dmem_arb_ctrl.sv
// Data-memory access controller: arbitrates a single-port synchronous RAM between
// the pipeline load/store port and a word-only debug port, with hardware RMW for SB/SH.
module dmem_arb_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              p_req_i,
   input  logic              p_we_i,
   input  logic [2:0]        p_funct3_i,
   input  logic [ADDR_W-1:0] p_addr_i,
   input  logic [31:0]       p_wdata_i,
   output logic              p_ready_o,
   output logic              p_err_o,
   output logic [31:0]       p_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [31:0]       d_wdata_i,
   output logic              d_ready_o,
   output logic [31:0]       d_rdata_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   input  logic [31:0]       ram_rdata_i
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t state, state_nxt;

   // Holding registers: the RAM only ever sees these, never the live request inputs.
   logic              own_d;
   logic              last_d;
   logic              hold_we;
   logic              hold_half;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_word;

   logic grant_p;
   logic grant_d;
   logic grant_any;
   logic p_bad;

   // Misaligned or illegal funct3 for the pipeline port.
   function automatic logic access_bad(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (we) begin
         bad = (f3 > 3'd2);
      end else begin
         bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      if ((f3[1:0] == 2'b01) && lo[0]) begin
         bad = 1'b1;
      end
      if ((f3[1:0] == 2'b10) && (lo != 2'b00)) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

   // Replace one byte or half of the old RAM word with right-aligned store data.
   function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic              is_half,
                                                    input logic [1:0]        lo);
      logic [DATA_W-1:0] w;
      w = old_word;
      if (is_half) begin
         if (lo[1]) begin
            w[31:16] = wdata[15:0];
         end else begin
            w[15:0] = wdata[15:0];
         end
      end else begin
         case (lo)
            2'd0:    w[7:0]   = wdata[7:0];
            2'd1:    w[15:8]  = wdata[7:0];
            2'd2:    w[23:16] = wdata[7:0];
            default: w[31:24] = wdata[7:0];
         endcase
      end
      return w;
   endfunction

   // Round-robin between two ports: on a tie the port not granted last wins.
   always_comb begin
      grant_p   = p_req_i && (!d_req_i || last_d);
      grant_d   = d_req_i && !grant_p;
      grant_any = (state == S_IDLE) && (grant_p || grant_d);
      p_bad     = access_bad(p_we_i, p_funct3_i, p_addr_i[1:0]);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (grant_d) begin
               state_nxt = d_we_i ? S_WRITE : S_READ;
            end else if (grant_p) begin
               if (p_bad) begin
                  state_nxt = S_ERR;
               end else if (!p_we_i) begin
                  state_nxt = S_READ;
               end else if (p_funct3_i == 3'd2) begin
                  state_nxt = S_WRITE;
               end else begin
                  state_nxt = S_READ;
               end
            end
         end
         S_READ:  state_nxt = S_MERGE;
         S_MERGE: state_nxt = hold_we ? S_WRITE : S_IDLE;
         S_WRITE: state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant latch and merged-word register
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         own_d     <= 1'b0;
         last_d    <= 1'b1;
         hold_we   <= 1'b0;
         hold_half <= 1'b0;
         hold_addr <= '0;
         hold_word <= '0;
      end else if (grant_any) begin
         own_d     <= grant_d;
         last_d    <= grant_d;
         hold_we   <= grant_d ? d_we_i : p_we_i;
         hold_half <= grant_d ? 1'b0 : p_funct3_i[0];
         hold_addr <= grant_d ? d_addr_i : p_addr_i;
         hold_word <= grant_d ? d_wdata_i : p_wdata_i;
      end else if ((state == S_MERGE) && hold_we) begin
         hold_word <= merge_word(ram_rdata_i, hold_word, hold_half, hold_addr[1:0]);
      end
   end

   // Output decode from state and owner; everything forced low while in reset.
   always_comb begin
      p_ready_o   = 1'b0;
      p_err_o     = 1'b0;
      p_rdata_o   = '0;
      d_ready_o   = 1'b0;
      d_rdata_o   = '0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (arst_n) begin
         ram_addr_o = {hold_addr[ADDR_W-1:2], 2'b00};
         case (state)
            S_READ: begin
               ram_en_o = 1'b1;
            end
            S_MERGE: begin
               if (!hold_we) begin
                  if (own_d) begin
                     d_ready_o = 1'b1;
                     d_rdata_o = ram_rdata_i;
                  end else begin
                     p_ready_o = 1'b1;
                     p_rdata_o = ram_rdata_i;
                  end
               end
            end
            S_WRITE: begin
               ram_en_o    = 1'b1;
               ram_we_o    = 1'b1;
               ram_wdata_o = hold_word;
               d_ready_o   = own_d;
               p_ready_o   = !own_d;
            end
            S_ERR: begin
               p_ready_o = 1'b1;
               p_err_o   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arb_ctrl.sv
// Scoreboard bench for dmem_arb_ctrl: drivers push expected responses and RAM
// strobes into queues, a negedge monitor pops and compares.
module tb_dmem_arb_ctrl;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        p_req = 1'b0, p_we = 1'b0;
   logic [2:0]  p_f3 = '0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic        p_ready, p_err;
   logic [31:0] p_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        ram_en, ram_we;
   logic [31:0] ram_addr, ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] mem [0:63];

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int k;

   typedef struct {
      logic        err;
      logic        chk_data;
      logic [31:0] data;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   resp_t       p_q[$];
   resp_t       d_q[$];
   wr_t         w_q[$];
   logic [31:0] r_q[$];

   dmem_arb_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .arst_n(arst_n),
      .p_req_i(p_req), .p_we_i(p_we), .p_funct3_i(p_f3), .p_addr_i(p_addr),
      .p_wdata_i(p_wdata), .p_ready_o(p_ready), .p_err_o(p_err), .p_rdata_o(p_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_ready_o(d_ready), .d_rdata_o(d_rdata),
      .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous RAM model
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr[7:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Monitor: every ready pulse and RAM strobe must match the head of its queue.
   always @(negedge clk) begin
      resp_t       r;
      wr_t         w;
      logic [31:0] a;
      if (p_ready) begin
         if (p_q.size() == 0) unexpected("p_ready");
         else begin
            r = p_q.pop_front();
            check("p_err", {31'b0, p_err}, {31'b0, r.err});
            check("p_cycle", 32'(cyc), 32'(r.cyc));
            if (r.chk_data) check("p_rdata", p_rdata, r.data);
         end
      end else if (p_err) unexpected("p_err_without_ready");
      if (d_ready) begin
         if (d_q.size() == 0) unexpected("d_ready");
         else begin
            r = d_q.pop_front();
            check("d_cycle", 32'(cyc), 32'(r.cyc));
            if (r.chk_data) check("d_rdata", d_rdata, r.data);
         end
      end
      if (ram_en && ram_we) begin
         if (w_q.size() == 0) unexpected("ram_write");
         else begin
            w = w_q.pop_front();
            check("ram_waddr", ram_addr, w.addr);
            check("ram_wdata", ram_wdata, w.data);
         end
      end
      if (ram_en && !ram_we) begin
         if (r_q.size() == 0) unexpected("ram_read");
         else begin
            a = r_q.pop_front();
            check("ram_raddr", ram_addr, a);
         end
      end
   end

   task automatic p_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err, input logic chk,
                           input logic [31:0] exp_data, input int exp_cyc);
      int n;
      n = 0;
      p_q.push_back('{exp_err, chk, exp_data, exp_cyc});
      p_req = 1'b1; p_we = we; p_f3 = f3; p_addr = addr; p_wdata = wdata;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!p_ready && n < 40);
      if (!p_ready) unexpected("p_timeout");
      @(posedge clk); #1;
      p_req = 1'b0;
   endtask

   task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic chk, input logic [31:0] exp_data, input int exp_cyc);
      int n;
      n = 0;
      d_q.push_back('{1'b0, chk, exp_data, exp_cyc});
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!d_ready && n < 40);
      if (!d_ready) unexpected("d_timeout");
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   task automatic check_outputs_zero();
      check("rst_p_ready", {31'b0, p_ready}, 32'h0);
      check("rst_d_ready", {31'b0, d_ready}, 32'h0);
      check("rst_p_err", {31'b0, p_err}, 32'h0);
      check("rst_ram_en", {31'b0, ram_en}, 32'h0);
      check("rst_ram_we", {31'b0, ram_we}, 32'h0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_p_rdata", p_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
   endtask

   initial begin
      // Reset with a request pending: nothing must come out.
      p_req = 1'b1; p_we = 1'b1; p_f3 = 3'd2; p_addr = 32'h10; p_wdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero();
      p_req = 1'b0;
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(posedge clk); #1;

      // Basic word traffic
      w_q.push_back('{32'h10, 32'hDEAD_BEEF});
      d_access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, cyc + 1);
      r_q.push_back(32'h10);
      p_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, cyc + 2);

      // SB into the top byte lane, upper store bits ignored
      w_q.push_back('{32'h10, 32'h1122_3344});
      d_access(1'b1, 32'h13, 32'h1122_3344, 1'b0, 32'h0, cyc + 1);
      r_q.push_back(32'h10);
      w_q.push_back('{32'h10, 32'hAA22_3344});
      p_access(1'b1, 3'd0, 32'h13, 32'h5555_55AA, 1'b0, 1'b0, 32'h0, cyc + 3);

      // SH into the upper half
      w_q.push_back('{32'h10, 32'h1122_3344});
      d_access(1'b1, 32'h10, 32'h1122_3344, 1'b0, 32'h0, cyc + 1);
      r_q.push_back(32'h10);
      w_q.push_back('{32'h10, 32'hBEEF_3344});
      p_access(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0, cyc + 3);

      // Misaligned and illegal accesses: error one cycle later, no RAM strobe
      p_access(1'b1, 3'd1, 32'h11, 32'h0000_1234, 1'b1, 1'b0, 32'h0, cyc + 1);
      p_access(1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, cyc + 1);
      p_access(1'b1, 3'd3, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, cyc + 1);
      p_access(1'b0, 3'd2, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0, cyc + 1);
      p_access(1'b1, 3'd2, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0, cyc + 1);
      p_access(1'b0, 3'd5, 32'h13, 32'h0, 1'b1, 1'b0, 32'h0, cyc + 1);

      // Legal sub-word loads return the raw aligned word
      r_q.push_back(32'h10);
      p_access(1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 1'b1, 32'hBEEF_3344, cyc + 2);
      r_q.push_back(32'h10);
      p_access(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b1, 32'hBEEF_3344, cyc + 2);

      // Debug read, also leaves the last grant with D
      r_q.push_back(32'h10);
      d_access(1'b0, 32'h12, 32'h0, 1'b1, 32'hBEEF_3344, cyc + 2);

      // Both ports requesting continuously: P, D, P, D ...
      k = cyc;
      for (int i = 0; i < 3; i++) begin
         r_q.push_back(32'h10);
         w_q.push_back('{32'h20, 32'h0000_0055});
      end
      fork
         for (int ip = 0; ip < 3; ip++)
            p_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'hBEEF_3344, k + 2 + 5 * ip);
         for (int id = 0; id < 3; id++)
            d_access(1'b1, 32'h20, 32'h0000_0055, 1'b0, 32'h0, k + 4 + 5 * id);
      join
      r_q.push_back(32'h20);
      d_access(1'b0, 32'h20, 32'h0, 1'b1, 32'h0000_0055, cyc + 2);

      // D arrives mid-RMW: waits for the P write, then reads the merged word
      k = cyc;
      r_q.push_back(32'h10);
      w_q.push_back('{32'h10, 32'hBEEF_3377});
      r_q.push_back(32'h10);
      fork
         p_access(1'b1, 3'd0, 32'h10, 32'h0000_0077, 1'b0, 1'b0, 32'h0, k + 3);
         begin
            @(posedge clk); #1;
            d_access(1'b0, 32'h10, 32'h0, 1'b1, 32'hBEEF_3377, k + 6);
         end
      join

      // Reset during MERGE of an SB: no write, RAM unchanged
      w_q.push_back('{32'h10, 32'h1122_3344});
      d_access(1'b1, 32'h10, 32'h1122_3344, 1'b0, 32'h0, cyc + 1);
      r_q.push_back(32'h10);
      p_req = 1'b1; p_we = 1'b1; p_f3 = 3'd0; p_addr = 32'h13; p_wdata = 32'h0000_00AA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      arst_n = 1'b0;
      p_req = 1'b0;
      #1;
      check_outputs_zero();
      @(posedge clk); #1;
      check_outputs_zero();
      arst_n = 1'b1;
      @(posedge clk); #1;
      r_q.push_back(32'h10);
      p_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 1'b1, 32'h1122_3344, cyc + 2);

      repeat (3) @(posedge clk);
      #1;
      check("p_q_drained", 32'(p_q.size()), 32'h0);
      check("d_q_drained", 32'(d_q.size()), 32'h0);
      check("w_q_drained", 32'(w_q.size()), 32'h0);
      check("r_q_drained", 32'(r_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
